matmul_apb_master: RTL and testbench
====================================

MATMUL_APB_MASTER -- requirements
Module: matmul_apb_master

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 32, APB data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-003 The block SHALL have parameter MAX_DIM, default 4, strobe width (one bit per byte lane).
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 255, max ACCESS-phase wait; 0 disables the timeout.
REQ-005 Port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-006 Port: rst_i  input  1  asynchronous, active-high reset.
REQ-007 Port: cmd_valid_i  input  1  command request.
REQ-008 Port: cmd_ready_o  output  1  command accepted when valid and ready are both high.
REQ-009 Port: cmd_write_i  input  1  1 = write, 0 = read.
REQ-010 Port: cmd_addr_i  input  ADDR_WIDTH  target address.
REQ-011 Port: cmd_wdata_i  input  BUS_WIDTH  write data.
REQ-012 Port: cmd_strb_i  input  MAX_DIM  write byte strobes.
REQ-013 Port: rsp_valid_o  output  1  response available.
REQ-014 Port: rsp_ready_i  input  1  response consumed when valid and ready are both high.
REQ-015 Port: rsp_rdata_o  output  BUS_WIDTH  read data; 0 for writes and timeouts.
REQ-016 Port: rsp_err_o  output  1  slave error or timeout.
REQ-017 Port: rsp_timeout_o  output  1  transfer ended by timeout.
REQ-018 Ports: psel_o, penable_o, pwrite_o (1 each), paddr_o (ADDR_WIDTH), pwdata_o (BUS_WIDTH), pstrb_o (MAX_DIM); all outputs driving the matmul DUT APB slave.
REQ-019 Ports: pready_i, pslverr_i (1 each), prdata_i (BUS_WIDTH); inputs from the matmul DUT.

Function
REQ-020 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP, and all outputs SHALL be driven from registers.
REQ-021 In IDLE, cmd_ready_o SHALL be 1; in all other states it SHALL be 0, so at most one transfer is outstanding.
REQ-022 On handshake in IDLE, the block SHALL register the address, write flag, wdata and strobes, and go to SETUP on the next cycle.
REQ-023 In SETUP: psel_o=1, penable_o=0; next state is unconditionally ACCESS.
REQ-024 In ACCESS: psel_o=1, penable_o=1; the block SHALL remain in ACCESS while pready_i=0 and the timeout has not expired.
REQ-025 In SETUP and ACCESS, paddr_o, pwrite_o, pwdata_o and pstrb_o SHALL stay stable at the registered command values.
REQ-026 pstrb_o SHALL be all-zero for read transfers regardless of cmd_strb_i.
REQ-027 When pready_i=1 in ACCESS, the block SHALL capture rsp_rdata_o (prdata_i for reads, 0 for writes) and rsp_err_o=pslverr_i, clear rsp_timeout_o, drop psel_o/penable_o, and enter RESP.
REQ-028 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with pready_i=0.
REQ-029 When TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES with pready_i still 0, the block SHALL drop psel_o/penable_o, set rsp_err_o=1, rsp_timeout_o=1 and rsp_rdata_o=0, and enter RESP.
REQ-030 If pready_i=1 in the same cycle the timeout is reached, pready_i SHALL take precedence (normal completion).
REQ-031 In RESP, rsp_valid_o=1 and the response fields SHALL be held until rsp_ready_i=1; then the block returns to IDLE next cycle.
REQ-032 Minimum latency SHALL be: accept at cycle N, SETUP at N+1, ACCESS at N+2 (pready_i=1), rsp_valid_o at N+3, cmd_ready_o again at N+4 if rsp_ready_i=1 at N+3.
REQ-033 pready_i, pslverr_i and prdata_i SHALL be ignored outside ACCESS.
REQ-034 In IDLE and RESP, paddr_o/pwdata_o/pwrite_o SHALL hold their last values, and pstrb_o SHALL be 0.

Reset
REQ-035 While rst_i=1 (asserted asynchronously), the state SHALL be IDLE, and all outputs SHALL be 0 except cmd_ready_o, which SHALL be 1 after release.
REQ-036 Reset asserted mid-transfer (SETUP/ACCESS/RESP) SHALL immediately drop psel_o/penable_o/rsp_valid_o and discard the transfer, with no response generated.

Verification
REQ-037 Write 0x0000_0010, data 0xDEADBEEF, strb 0xF, pready_i=1 first ACCESS cycle -> SETUP/ACCESS each 1 cycle, pstrb_o=0xF, rsp_valid_o at N+3, rsp_err_o=0, rsp_rdata_o=0.
REQ-038 Read 0x0000_0020, pready_i low 3 ACCESS cycles then high with prdata_i=0x1234_5678 -> ACCESS lasts 4 cycles, pstrb_o=0, rsp_rdata_o=0x1234_5678, paddr_o stable throughout.
REQ-039 Write with pslverr_i=1 at pready_i -> rsp_err_o=1, rsp_timeout_o=0.
REQ-040 TIMEOUT_CYCLES=4, pready_i held 0 -> psel_o drops after 4 waiting ACCESS cycles, rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0; pready_i=1 exactly on the 4th cycle -> normal completion instead.
REQ-041 rsp_ready_i held 0 for 5 cycles, new cmd_valid_i pending -> rsp held stable, cmd_ready_o=0 until one cycle after rsp_ready_i=1.
REQ-042 rst_i pulsed during ACCESS -> psel_o/penable_o=0 in the same cycle, no rsp_valid_o, next command completes normally.

Source files
------------

// File: rtl/matmul_apb_master.sv
// APB master that turns single command/response transfers into APB SETUP/ACCESS cycles.
// Every output is registered, and the ACCESS phase has an optional wait-state timeout.
module matmul_apb_master #(
   parameter int unsigned BUS_WIDTH      = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned MAX_DIM        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // command channel
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_write_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
   input  logic [MAX_DIM-1:0]    cmd_strb_i,
   // response channel
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  rsp_timeout_o,
   // APB master side
   output logic                  psel_o,
   output logic                  penable_o,
   output logic                  pwrite_o,
   output logic [ADDR_WIDTH-1:0] paddr_o,
   output logic [BUS_WIDTH-1:0]  pwdata_o,
   output logic [MAX_DIM-1:0]    pstrb_o,
   input  logic                  pready_i,
   input  logic                  pslverr_i,
   input  logic [BUS_WIDTH-1:0]  prdata_i
);

   // The wait counter only has to reach TIMEOUT_CYCLES-1; the final wait cycle fires the timeout.
   localparam int unsigned   CntW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit            TimeoutEn = (TIMEOUT_CYCLES != 0);
   localparam logic [CntW-1:0] WaitLast =
      CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       wait_q, wait_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [BUS_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [BUS_WIDTH-1:0]  pwdata_q, pwdata_d;
   logic [MAX_DIM-1:0]    pstrb_q, pstrb_d;
   logic                  timeout_hit;

   assign timeout_hit = TimeoutEn && (wait_q == WaitLast);

   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      cmd_ready_d   = cmd_ready_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      pstrb_d       = pstrb_q;

      unique case (state_q)
         StIdle: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid_i && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               psel_d      = 1'b1;
               pwrite_d    = cmd_write_i;
               paddr_d     = cmd_addr_i;
               pwdata_d    = cmd_wdata_i;
               pstrb_d     = cmd_write_i ? cmd_strb_i : '0;
               state_d     = StSetup;
            end
         end
         StSetup: begin
            penable_d = 1'b1;
            wait_d    = '0;
            state_d   = StAccess;
         end
         StAccess: begin
            // pready wins over a timeout landing in the same cycle
            if (pready_i) begin
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               pstrb_d       = '0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
               rsp_err_d     = pslverr_i;
               rsp_timeout_d = 1'b0;
               state_d       = StResp;
            end else if (timeout_hit) begin
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               pstrb_d       = '0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               state_d       = StResp;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         StResp: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= StIdle;
         wait_q        <= '0;
         cmd_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pstrb_q       <= '0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         cmd_ready_q   <= cmd_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         pstrb_q       <= pstrb_d;
      end
   end

   assign cmd_ready_o   = cmd_ready_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_rdata_o   = rsp_rdata_q;
   assign rsp_err_o     = rsp_err_q;
   assign rsp_timeout_o = rsp_timeout_q;
   assign psel_o        = psel_q;
   assign penable_o     = penable_q;
   assign pwrite_o      = pwrite_q;
   assign paddr_o       = paddr_q;
   assign pwdata_o      = pwdata_q;
   assign pstrb_o       = pstrb_q;

endmodule

// File: tb/tb_matmul_apb_master.sv
// Directed bench for matmul_apb_master: the driver queues expected responses, and a
// monitor pops and compares each one when it is consumed.
module tb_matmul_apb_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        psel, penable, pwrite, pready, pslverr;
   logic [31:0] paddr, pwdata, prdata;
   logic [3:0]  pstrb;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic        to;
   } rsp_t;

   rsp_t exp_q[$];
   rsp_t exp_m;

   always #5 clk = ~clk;

   matmul_apb_master #(
      .BUS_WIDTH      (32),
      .ADDR_WIDTH     (32),
      .MAX_DIM        (4),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .cmd_valid_i   (cmd_valid),
      .cmd_ready_o   (cmd_ready),
      .cmd_write_i   (cmd_write),
      .cmd_addr_i    (cmd_addr),
      .cmd_wdata_i   (cmd_wdata),
      .cmd_strb_i    (cmd_strb),
      .rsp_valid_o   (rsp_valid),
      .rsp_ready_i   (rsp_ready),
      .rsp_rdata_o   (rsp_rdata),
      .rsp_err_o     (rsp_err),
      .rsp_timeout_o (rsp_timeout),
      .psel_o        (psel),
      .penable_o     (penable),
      .pwrite_o      (pwrite),
      .paddr_o       (paddr),
      .pwdata_o      (pwdata),
      .pstrb_o       (pstrb),
      .pready_i      (pready),
      .pslverr_i     (pslverr),
      .prdata_i      (prdata)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: a response is consumed on the edge after a negedge with valid & ready.
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected actual=rsp_valid=1 required=no response pending");
         end else begin
            exp_m = exp_q.pop_front();
            chk("rsp_rdata", 128'(rsp_rdata), 128'(exp_m.rdata));
            chk("rsp_err", 128'(rsp_err), 128'(exp_m.err));
            chk("rsp_timeout", 128'(rsp_timeout), 128'(exp_m.to));
         end
      end
   end

   // pready_at: ACCESS cycle index (0-based) with pready=1, or -1 to let the timeout fire.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int pready_at, input logic slverr,
                       input logic [31:0] rdata, input int hold);
      logic [3:0] es;
      rsp_t       e;
      logic       done;
      es        = wr ? strb : 4'h0;
      e.to      = (pready_at < 0);
      e.err     = e.to ? 1'b1 : slverr;
      e.rdata   = (wr || e.to) ? 32'h0 : rdata;
      rsp_ready = (hold == 0);
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_strb  = strb;
      @(negedge clk);
      chk("accept_ready", 128'(cmd_ready), 128'(1));
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_write = ~wr;
      cmd_addr  = ~addr;
      cmd_wdata = ~wdata;
      cmd_strb  = ~strb;
      pready    = 1'b1;
      prdata    = 32'hFFFF_0000;
      @(negedge clk);
      chk("setup_bus", {psel, penable, pwrite, paddr, pwdata, pstrb, cmd_ready},
          {1'b1, 1'b0, wr, addr, wdata, es, 1'b0});
      done = 1'b0;
      for (int k = 0; k < 4 && !done; k++) begin
         @(posedge clk); #1;
         pready  = (k == pready_at);
         pslverr = slverr;
         prdata  = (k == pready_at) ? rdata : 32'hBAD0_0000 | 32'(k);
         @(negedge clk);
         chk("access_bus", {psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid},
             {1'b1, 1'b1, wr, addr, wdata, es, 1'b0});
         if (k == pready_at) done = 1'b1;
      end
      exp_q.push_back(e);
      @(posedge clk); #1;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = 32'h0BAD_F00D;
      @(negedge clk);
      chk("resp_bus", {psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, cmd_ready},
          {1'b0, 1'b0, wr, addr, wdata, 4'h0, 1'b1, 1'b0});
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b1;
         @(negedge clk);
         chk("hold_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready},
             {1'b1, e.rdata, e.err, e.to, 1'b0});
      end
      if (hold != 0) begin
         @(posedge clk); #1;
         rsp_ready = 1'b1;
         cmd_valid = 1'b0;
         @(negedge clk);
         chk("hold_release", {rsp_valid, cmd_ready}, {1'b1, 1'b0});
      end
      @(posedge clk);
      @(negedge clk);
      chk("back_idle", {cmd_ready, rsp_valid, psel, pstrb}, {1'b1, 1'b0, 1'b0, 4'h0});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 32'h0;
      cmd_wdata = 32'h0;
      cmd_strb  = 4'h0;
      rsp_ready = 1'b1;
      pready    = 1'b0;
      pslverr   = 1'b0;
      prdata    = 32'h0;
      #12;
      chk("reset_outputs", {cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, penable,
                            pwrite, paddr, pwdata, pstrb}, 128'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", {cmd_ready, psel}, {1'b1, 1'b0});

      xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0, 0);
      xfer(1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 3, 1'b0, 32'h1234_5678, 0);
      xfer(1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'h3, 1, 1'b1, 32'h0, 0);
      xfer(1'b0, 32'h0000_0044, 32'h0000_0000, 4'h0, -1, 1'b0, 32'h5555_AAAA, 0);
      xfer(1'b1, 32'h0000_0050, 32'h0102_0304, 4'h8, 3, 1'b0, 32'h0, 0);
      xfer(1'b0, 32'h0000_0060, 32'h0000_0000, 4'h1, 0, 1'b0, 32'hA5A5_5A5A, 5);

      // Reset during ACCESS: bus drops at once and the transfer vanishes.
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h0000_0080;
      cmd_wdata = 32'h1111_2222;
      cmd_strb  = 4'hF;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      pready = 1'b0;
      @(negedge clk);
      chk("abort_in_access", {psel, penable}, {1'b1, 1'b1});
      #2 rst = 1'b1;
      #1;
      chk("abort_async", {psel, penable, rsp_valid, cmd_ready}, 128'h0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("abort_no_rsp", {cmd_ready, rsp_valid, psel, penable}, {1'b1, 1'b0, 1'b0, 1'b0});

      xfer(1'b0, 32'h0000_0070, 32'h0000_0000, 4'hF, 0, 1'b0, 32'h0BEE_F123, 0);

      chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
